route_lookup_engine: RTL and testbench

Parametrised routing-table lookup engine, the successor to the fixed 8-entry/4-port router. It holds DEPTH entries of {valid, address, port}, configured by indexed write/invalidate commands. Lookups arrive on a valid/ready request channel and return {hit, index, port} on a registered valid/ready response channel. Invalid entries never match, unmatched addresses route to DEFAULT_PORT, and saturating hit/miss counters are exposed for status.

---
 rtl/router_pkg.sv | 26 ++
 rtl/route_cam_match.sv | 32 +++
 rtl/route_lookup_engine.sv | 163 ++++++++++++++++
 tb/tb_route_lookup_engine.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and width helpers for the route lookup engine.
package router_pkg;

  // Configuration command encoding carried on cfg_op.
  typedef enum logic {
    CFG_WRITE = 1'b0,
    CFG_INVAL = 1'b1
  } cfg_op_e;

  // Result register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  // Index width for a table of the given depth (never narrower than 1 bit).
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Port-number width for the given port count (never narrower than 1 bit).
  function automatic int port_width(input int nports);
    return (nports <= 2) ? 1 : $clog2(nports);
  endfunction

endpackage

// File: rtl/route_cam_match.sv
// DEPTH-way address compare with a lowest-index-wins priority encoder.
module route_cam_match
  import router_pkg::*;
#(
  parameter  int ADDR_W = 8,
  parameter  int DEPTH  = 8,
  localparam int IDX_W  = idx_width(DEPTH)
) (
  input  logic [DEPTH-1:0]             entry_valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr_i,
  input  logic [ADDR_W-1:0]            lk_addr_i,
  output logic                         hit_o,
  output logic [IDX_W-1:0]             index_o
);

  logic [DEPTH-1:0] match;

  // An entry only matches while its valid bit is set.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign match[gi] = entry_valid_i[gi] && (entry_addr_i[gi] == lk_addr_i);
  end

  // Scan from the top down so the lowest matching index is the last one kept.
  always_comb begin
    hit_o   = |match;
    index_o = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match[i]) index_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/route_lookup_engine.sv
// Routing-table lookup engine: indexed config, CAM lookup, registered
// valid/ready result and saturating hit/miss counters.
module route_lookup_engine
  import router_pkg::*;
#(
  parameter  int ADDR_W       = 8,
  parameter  int DEPTH        = 8,
  parameter  int NPORTS       = 4,
  parameter  int DEFAULT_PORT = 0,
  parameter  int CNT_W        = 16,
  localparam int IDX_W        = idx_width(DEPTH),
  localparam int PORT_W       = port_width(NPORTS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_op,
  input  logic [IDX_W-1:0]  cfg_index,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [PORT_W-1:0] cfg_port,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_hit,
  output logic [IDX_W-1:0]  res_index,
  output logic [PORT_W-1:0] res_port,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam logic [IDX_W:0]    DEPTH_LIM  = (IDX_W + 1)'(DEPTH);
  localparam logic [PORT_W:0]   NPORTS_LIM = (PORT_W + 1)'(NPORTS);
  localparam logic [PORT_W-1:0] DEF_PORT   = PORT_W'(DEFAULT_PORT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

  // Table storage
  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  addr_q;
  logic [DEPTH-1:0][PORT_W-1:0]  port_q;

  // Config decode
  logic                  cfg_is_write;
  logic                  cfg_in_range;
  logic [PORT_W-1:0]     cfg_port_eff;
  logic [DEPTH-1:0]      wr_sel;

  // Lookup / output path
  logic                  accept;
  logic                  cam_hit;
  logic [IDX_W-1:0]      cam_index;
  out_state_e            state_q;
  logic                  res_hit_q;
  logic [IDX_W-1:0]      res_index_q;
  logic [PORT_W-1:0]     res_port_q;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;

  assign cfg_ready    = 1'b1;
  assign cfg_is_write = (cfg_op_e'(cfg_op) == CFG_WRITE);
  // Indices past the last entry (non-power-of-two depth) are dropped.
  assign cfg_in_range = ({1'b0, cfg_index} < DEPTH_LIM);
  // Out-of-range port numbers fall back to the default port at write time.
  assign cfg_port_eff = ({1'b0, cfg_port} < NPORTS_LIM) ? cfg_port : DEF_PORT;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign wr_sel[gi] = cfg_valid && cfg_in_range && (cfg_index == IDX_W'(gi));
  end

  // Valid bits: set by WRITE, cleared by INVALIDATE, all cleared on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) valid_q[i] <= cfg_is_write;
      end
    end
  end

  // Address/port payload only changes on WRITE; INVALIDATE leaves it intact.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_sel[i] && cfg_is_write) begin
        addr_q[i] <= cfg_addr;
        port_q[i] <= cfg_port_eff;
      end
    end
  end

  // Compare against the pre-edge table, so a same-cycle write is not seen.
  route_cam_match #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_cam (
    .entry_valid_i (valid_q),
    .entry_addr_i  (addr_q),
    .lk_addr_i     (lk_addr),
    .hit_o         (cam_hit),
    .index_o       (cam_index)
  );

  assign res_valid = (state_q == FULL);
  // Combinational from res_ready so a draining slot refills in the same cycle.
  assign lk_ready  = !res_valid || res_ready;
  assign accept    = lk_valid && lk_ready;

  // Output FSM with the result fields; fields only load on accept, so they
  // hold steady while the consumer stalls regardless of config traffic.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      res_hit_q   <= 1'b0;
      res_index_q <= '0;
      res_port_q  <= DEF_PORT;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_q <= FULL;
        FULL:  if (!accept && res_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      if (accept) begin
        res_hit_q   <= cam_hit;
        res_index_q <= cam_hit ? cam_index : '0;
        res_port_q  <= cam_hit ? port_q[cam_index] : DEF_PORT;
      end
    end
  end

  assign res_hit   = res_hit_q;
  assign res_index = res_index_q;
  assign res_port  = res_port_q;

  // Next counter values: bump the matching counter, sticking at all-ones.
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (accept) begin
      if (cam_hit) begin
        if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end else begin
        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter registers, cleared asynchronously with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_route_lookup_engine.sv
// Bench for route_lookup_engine: directed steps plus random traffic, checked
// against a table-search reference model. A second instance with narrow
// counters and three ports shares all inputs.
module tb_route_lookup_engine;

  localparam int DEPTH = 6;
  localparam int DEF1  = 1;
  localparam int NP2   = 3;
  localparam int DEF2  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_valid, cfg_op;
  logic [2:0] cfg_index;
  logic [7:0] cfg_addr;
  logic [1:0] cfg_port;
  logic       lk_valid;
  logic [7:0] lk_addr;
  logic       res_ready;

  logic        cfg_ready1, lk_ready1, res_valid1, res_hit1;
  logic [2:0]  res_index1;
  logic [1:0]  res_port1;
  logic [15:0] hit1, miss1;
  logic        cfg_ready2, lk_ready2, res_valid2, res_hit2;
  logic [2:0]  res_index2;
  logic [1:0]  res_port2;
  logic [1:0]  hit2, miss2;

  route_lookup_engine #(.ADDR_W(8), .DEPTH(DEPTH), .NPORTS(4), .DEFAULT_PORT(DEF1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready1), .cfg_op(cfg_op),
    .cfg_index(cfg_index), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .lk_valid(lk_valid),
    .lk_ready(lk_ready1), .lk_addr(lk_addr), .res_valid(res_valid1), .res_ready(res_ready),
    .res_hit(res_hit1), .res_index(res_index1), .res_port(res_port1),
    .hit_count(hit1), .miss_count(miss1));

  route_lookup_engine #(.ADDR_W(8), .DEPTH(DEPTH), .NPORTS(NP2), .DEFAULT_PORT(DEF2), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2), .cfg_op(cfg_op),
    .cfg_index(cfg_index), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .lk_valid(lk_valid),
    .lk_ready(lk_ready2), .lk_addr(lk_addr), .res_valid(res_valid2), .res_ready(res_ready),
    .res_hit(res_hit2), .res_index(res_index2), .res_port(res_port2),
    .hit_count(hit2), .miss_count(miss2));

  always #5 clk = ~clk;

  // Reference model state
  bit         m_valid [DEPTH];
  logic [7:0] m_addr  [DEPTH];
  logic [1:0] m_port  [DEPTH];
  bit         m_rv, m_hit;
  int         m_idx;
  logic [1:0] m_rport;
  int         m_hits, m_miss;
  int         errors = 0;
  int         checks = 0;

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_rv = 1'b0; m_hit = 1'b0; m_idx = 0; m_rport = 2'd0;
    m_hits = 0; m_miss = 0;
  endtask

  task automatic check_outputs();
    int p2;
    p2 = (m_hit && m_rport < NP2) ? int'(m_rport) : DEF2;
    check("cfg_ready", {31'd0, cfg_ready1}, 32'd1);
    check("res_valid", {31'd0, res_valid1}, {31'd0, m_rv});
    check("res_hit", {31'd0, res_hit1}, {31'd0, m_hit});
    check("res_index", {29'd0, res_index1}, m_hit ? m_idx : 0);
    check("res_port", {30'd0, res_port1}, m_hit ? {30'd0, m_rport} : DEF1);
    check("hit_count", {16'd0, hit1}, m_hits);
    check("miss_count", {16'd0, miss1}, m_miss);
    check("res_valid_n3", {31'd0, res_valid2}, {31'd0, m_rv});
    check("res_index_n3", {29'd0, res_index2}, m_hit ? m_idx : 0);
    check("res_port_n3", {30'd0, res_port2}, p2);
    check("hit_count_sat", {30'd0, hit2}, sat(m_hits, 2));
    check("miss_count_sat", {30'd0, miss2}, sat(m_miss, 2));
  endtask

  task automatic drive(input bit cv, input bit op, input int idx, input int addr, input int port,
                       input bit lv, input int la, input bit rr);
    cfg_valid = cv; cfg_op = op; cfg_index = 3'(idx); cfg_addr = 8'(addr); cfg_port = 2'(port);
    lk_valid = lv; lk_addr = 8'(la); res_ready = rr;
  endtask

  // One clock: check ready, advance the model across the edge, check results.
  task automatic step();
    bit acc, hit, exp_ready;
    int idx;
    #1;
    exp_ready = !m_rv || res_ready;
    check("lk_ready", {31'd0, lk_ready1}, {31'd0, exp_ready});
    check("lk_ready_n3", {31'd0, lk_ready2}, {31'd0, exp_ready});
    acc = lk_valid && exp_ready;
    hit = 1'b0; idx = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && m_valid[i] && m_addr[i] == lk_addr) begin hit = 1'b1; idx = i; end
    end
    @(posedge clk);
    if (acc) begin
      m_rv = 1'b1; m_hit = hit; m_idx = hit ? idx : 0;
      m_rport = hit ? m_port[idx] : 2'd0;
      if (hit) m_hits++; else m_miss++;
    end else if (res_ready) begin
      m_rv = 1'b0;
    end
    if (cfg_valid && int'(cfg_index) < DEPTH) begin
      if (cfg_op == 1'b0) begin
        m_valid[cfg_index] = 1'b1; m_addr[cfg_index] = cfg_addr; m_port[cfg_index] = cfg_port;
      end else begin
        m_valid[cfg_index] = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int a_sel, t;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();

    // Empty table: address 0 must miss.
    drive(0, 0, 0, 0, 0, 1, 8'h00, 1); step();
    // Two entries with the same address: lowest index wins, then fall-through.
    drive(1, 0, 2, 8'h5A, 3, 0, 0, 1); step();
    drive(1, 0, 5, 8'h5A, 1, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 1); step();
    drive(1, 1, 2, 0, 0, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 1); step();
    // Out-of-range index is ignored.
    drive(1, 0, 6, 8'h66, 2, 0, 0, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h66, 1); step();
    // Back-to-back lookups at full throughput.
    drive(0, 0, 0, 0, 0, 1, 8'h11, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h22, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h33, 1); step();
    // Stall with a held hit; rewrite the matched entry while stalled.
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 1); step();
    drive(1, 0, 5, 8'h5A, 0, 1, 8'h11, 0); step();
    repeat (3) begin drive(0, 0, 0, 0, 0, 1, 8'h11, 0); step(); end
    drive(0, 0, 0, 0, 0, 1, 8'h11, 1); step();
    // Same-cycle write and lookup: lookup sees the old table.
    drive(1, 0, 0, 8'h77, 2, 1, 8'h77, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h77, 1); step();

    // Random traffic over a small address set so hits are frequent.
    for (int n = 0; n < 250; n++) begin
      a_sel = $urandom_range(0, 3);
      t     = $urandom_range(0, 3);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            8'h10 + a_sel, $urandom_range(0, 3),
            $urandom_range(0, 9) < 7, 8'h10 + t, $urandom_range(0, 9) < 7);
      step();
    end

    // Reset while a result is held.
    drive(1, 0, 1, 8'h5A, 3, 1, 8'h5A, 1); step();
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0); step();
    check("held_before_reset", {31'd0, res_valid1}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_res_valid", {31'd0, res_valid1}, 32'd0);
    check("async_hit_count", {16'd0, hit1}, 32'd0);
    check("async_miss_count", {16'd0, miss1}, 32'd0);
    check("async_res_valid_n3", {31'd0, res_valid2}, 32'd0);
    check("async_miss_count_n3", {30'd0, miss2}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    model_reset();
    check("lk_ready_after_reset", {31'd0, lk_ready1}, 32'd1);
    check_outputs();
    // Table was invalidated by reset.
    drive(0, 0, 0, 0, 0, 1, 8'h5A, 1); step();
    drive(0, 0, 0, 0, 0, 0, 0, 1); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
